// File: rtl/mult4_accum_pkg.sv
// Shared definitions for the mult4_accum multiply-accumulate back end:
// state encodings, default widths and the state-to-control decode.
package mult4_accum_pkg;

    // Width of the product delivered by multiplier4.
    localparam int PROD_W     = 8;

    // Default geometry of the accumulator.
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_N_PROD = 8;
    localparam int DEF_CNT_W  = 4;

    // Frame controller states. The spare encoding is listed so that a
    // corrupted state register has a named value that recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2,
        ST_SPARE = 2'd3
    } state_t;

    // Control outputs that depend on the state register alone.
    typedef struct packed {
        logic busy;
        logic done;
        logic prod_ready;
    } ctrl_t;

    // Decode the handshake and status outputs from the current state.
    // The spare encoding behaves exactly like IDLE.
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_ACCUM: begin
                c.busy       = 1'b1;
                c.prod_ready = 1'b1;
            end
            ST_DONE: begin
                c.done       = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multiplier4.sv
// 4x4 unsigned combinational multiplier; its product feeds mult4_accum.
module multiplier4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] c
);

    // Operands are widened first so the product is computed at full width.
    assign c = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mult4_accum.sv
// Sequential multiply-accumulate back end. Accepts N_PROD unsigned 8-bit
// products through a valid/ready handshake, sums them into an ACC_W-bit
// wrapping accumulator and reports frame completion plus a sticky carry-out
// flag. busy, done and prod_ready are decoded from the state register only,
// so no input has a combinational path to any output.
module mult4_accum
    import mult4_accum_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int N_PROD = DEF_N_PROD,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // Zero bits needed to lift the product to the ACC_W+1 sum width.
    localparam int EXT_W = ACC_W + 1 - PROD_W;

    // Counter value that identifies the last product of a frame.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PROD - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;
    logic             overflow_next;

    // One extra bit on the sum captures the carry out of the accumulator.
    logic [ACC_W:0]   sum_full;
    logic             accept;
    ctrl_t            ctrl;

    assign ctrl     = decode_ctrl(state_reg);
    assign accept   = prod_valid & ctrl.prod_ready;
    assign sum_full = {1'b0, acc_reg} + {{EXT_W{1'b0}}, prod};

    // Register the state and datapath; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Next-state and datapath update; start outranks the handshake.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    acc_next      = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    state_next    = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (start) begin
                    // Abort and restart; a product offered now is dropped.
                    acc_next      = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    state_next    = ST_ACCUM;
                end else if (accept) begin
                    acc_next      = sum_full[ACC_W-1:0];
                    overflow_next = overflow_reg | sum_full[ACC_W];
                    count_next    = count_reg + CNT_W'(1);
                    if (count_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Results hold until the next frame is started.
                if (start) begin
                    acc_next      = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    state_next    = ST_ACCUM;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign prod_ready = ctrl.prod_ready;
    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign acc        = acc_reg;
    assign count      = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_mult4_accum.sv
// Self-checking bench for mult4_accum: table-driven frames through
// multiplier4, hand-written restart/reset sequences, an overflow instance,
// and random frames checked against a plain-arithmetic running-sum model.
module tb_mult4_accum;
    import mult4_accum_pkg::*;

    localparam int AW_A = 16;
    localparam int N_A  = 8;
    localparam int CW   = 4;
    localparam int AW_B = 10;
    localparam int N_B  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A: default geometry, fed by multiplier4.
    logic            start_a, valid_a, ready_a, busy_a, done_a, ovf_a;
    logic [3:0]      mul_a, mul_b;
    logic [7:0]      prod_a;
    logic [AW_A-1:0] acc_a;
    logic [CW-1:0]   count_a;

    // Instance B: narrow accumulator for overflow behaviour.
    logic            start_b, valid_b, ready_b, busy_b, done_b, ovf_b;
    logic [7:0]      prod_b;
    logic [AW_B-1:0] acc_b;
    logic [CW-1:0]   count_b;

    multiplier4 u_mul (.a(mul_a), .b(mul_b), .c(prod_a));

    mult4_accum #(.ACC_W(AW_A), .N_PROD(N_A), .CNT_W(CW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .prod(prod_a),
        .prod_valid(valid_a), .prod_ready(ready_a), .acc(acc_a),
        .count(count_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    mult4_accum #(.ACC_W(AW_B), .N_PROD(N_B), .CNT_W(CW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .prod(prod_b),
        .prod_valid(valid_b), .prod_ready(ready_b), .acc(acc_b),
        .count(count_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    int tests = 0;
    int fails = 0;

    // Cycles spent with busy high on instance A, sampled mid-cycle.
    int busy_cycles_a = 0;
    always @(negedge clk) if (busy_a === 1'b1) busy_cycles_a++;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         gap;
        int         exp_acc;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[8];
    int   gap_total;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] g_acc(input int d);
        return (d != 0) ? 32'(acc_b) : 32'(acc_a);
    endfunction
    function automatic logic [31:0] g_cnt(input int d);
        return (d != 0) ? 32'(count_b) : 32'(count_a);
    endfunction
    function automatic logic [31:0] g_ovf(input int d);
        return (d != 0) ? 32'(ovf_b) : 32'(ovf_a);
    endfunction
    function automatic logic [31:0] g_done(input int d);
        return (d != 0) ? 32'(done_b) : 32'(done_a);
    endfunction
    function automatic logic [31:0] g_busy(input int d);
        return (d != 0) ? 32'(busy_b) : 32'(busy_a);
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d != 0) start_b = v; else start_a = v;
    endtask
    task automatic set_valid(input int d, input logic v);
        if (d != 0) valid_b = v; else valid_a = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},   32'(acc_a),   0);
        check({tag, "_count"}, 32'(count_a), 0);
        check({tag, "_busy"},  32'(busy_a),  0);
        check({tag, "_done"},  32'(done_a),  0);
        check({tag, "_ovf"},   32'(ovf_a),   0);
        check({tag, "_ready"}, 32'(ready_a), 0);
    endtask

    // Run the table frame on instance A, optionally with gaps and a start.
    task automatic run_table(input bit do_start, input bit use_gaps, input string tag);
        int snap;
        int gaps;
        gaps = 0;
        snap = busy_cycles_a;
        if (do_start) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            check({tag, "_start_busy"}, 32'(busy_a), 1);
            check({tag, "_start_acc"},  32'(acc_a),  0);
        end
        for (int i = 0; i < 8; i++) begin
            mul_a   = tbl[i].a;
            mul_b   = tbl[i].b;
            valid_a = 1'b1;
            tick();
            valid_a = 1'b0;
            $display("[TB] %s handshake %0d: %0dx%0d acc=%0d count=%0d done=%0d",
                     tag, i + 1, tbl[i].a, tbl[i].b, acc_a, count_a, done_a);
            check({tag, "_acc"},   32'(acc_a),   32'(tbl[i].exp_acc));
            check({tag, "_count"}, 32'(count_a), 32'(tbl[i].exp_cnt));
            check({tag, "_done"},  32'(done_a),  (i == 7) ? 32'd1 : 32'd0);
            check({tag, "_ready"}, 32'(ready_a), (i == 7) ? 32'd0 : 32'd1);
            if (use_gaps && i < 7) begin
                for (int g = 0; g < tbl[i].gap; g++) begin
                    tick();
                    gaps++;
                    check({tag, "_gap_acc"},   32'(acc_a),   32'(tbl[i].exp_acc));
                    check({tag, "_gap_count"}, 32'(count_a), 32'(tbl[i].exp_cnt));
                    check({tag, "_gap_done"},  32'(done_a),  0);
                end
            end
        end
        check({tag, "_ovf"},  32'(ovf_a),  0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        if (do_start)
            check({tag, "_busy_cycles"}, 32'(busy_cycles_a - snap), 32'(8 + gaps));
    endtask

    // Random frame checked against an unbounded running total.
    task automatic rand_frame(input int d, input int idx);
        int     n;
        int     aw;
        longint total;
        longint modulus;
        logic [7:0] p;
        n       = (d != 0) ? N_B : N_A;
        aw      = (d != 0) ? AW_B : AW_A;
        modulus = longint'(1) << aw;
        total   = 0;
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
        check("rnd_start_acc", g_acc(d), 0);
        for (int k = 0; k < n; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("rnd_gap_count", g_cnt(d), 32'(k));
            end
            if (d != 0) begin
                p = 8'($urandom_range(0, 255));
                prod_b = p;
            end else begin
                mul_a = 4'($urandom_range(0, 15));
                mul_b = 4'($urandom_range(0, 15));
                p = 8'(int'(mul_a) * int'(mul_b));
            end
            set_valid(d, 1'b1);
            tick();
            set_valid(d, 1'b0);
            total += longint'(p);
            $display("[TB] rnd d%0d frame %0d prod %0d: p=%0d acc=%0d count=%0d ovf=%0d",
                     d, idx, k + 1, p, g_acc(d), g_cnt(d), g_ovf(d));
            check("rnd_acc",   g_acc(d), 32'(total % modulus));
            check("rnd_count", g_cnt(d), 32'(k + 1));
            check("rnd_ovf",   g_ovf(d), (total >= modulus) ? 32'd1 : 32'd0);
            check("rnd_done",  g_done(d), (k == n - 1) ? 32'd1 : 32'd0);
        end
        check("rnd_busy_end", g_busy(d), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'd10, 4'd12, 1, 120, 1};
        tbl[1] = '{4'd15, 4'd15, 3, 345, 2};
        tbl[2] = '{4'd0,  4'd0,  0, 345, 3};
        tbl[3] = '{4'd3,  4'd3,  2, 354, 4};
        tbl[4] = '{4'd3,  4'd3,  1, 363, 5};
        tbl[5] = '{4'd3,  4'd3,  0, 372, 6};
        tbl[6] = '{4'd3,  4'd3,  3, 381, 7};
        tbl[7] = '{4'd3,  4'd3,  0, 390, 8};
        gap_total = 0;
        for (int i = 0; i < 7; i++) gap_total += tbl[i].gap;

        // Test 1: reset held with start and valid asserted.
        reset = 1'b1; start_a = 1'b1; valid_a = 1'b1; mul_a = 4'd5; mul_b = 4'd5;
        start_b = 1'b1; valid_b = 1'b1; prod_b = 8'd7;
        tick();
        tick();
        check_all_zero("reset");
        check("reset_b_acc", 32'(acc_b), 0);
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy",  32'(busy_a),  0);
            check("idle_acc",   32'(acc_a),   0);
            check("idle_ready", 32'(ready_a), 0);
        end
        valid_a = 1'b0; valid_b = 1'b0;

        // Test 2: continuous-valid frame.
        run_table(1'b1, 1'b0, "full");

        // DONE ignores prod_valid.
        mul_a = 4'd15; mul_b = 4'd15; valid_a = 1'b1;
        tick();
        tick();
        valid_a = 1'b0;
        check("done_hold_acc",   32'(acc_a),   390);
        check("done_hold_count", 32'(count_a), 8);
        check("done_hold_done",  32'(done_a),  1);

        // Test 3: frame with valid gaps.
        run_table(1'b1, 1'b1, "gaps");
        $display("[TB] gap frame used %0d idle cycles", gap_total);

        // Test 4: overflow on the narrow instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            prod_b = 8'd225; valid_b = 1'b1;
            tick();
            valid_b = 1'b0;
            $display("[TB] ovf handshake %0d: acc=%0d ovf=%0d", k, acc_b, ovf_b);
            check("ovf_acc",  32'(acc_b), 32'((225 * k) % 1024));
            check("ovf_flag", 32'(ovf_b), (k == 5) ? 32'd1 : 32'd0);
        end
        check("ovf_done", 32'(done_b), 1);
        tick();
        check("ovf_sticky", 32'(ovf_b), 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("ovf_restart_clear", 32'(ovf_b), 0);
        check("ovf_restart_busy",  32'(busy_b), 1);
        for (int k = 0; k < 5; k++) begin
            prod_b = 8'd1; valid_b = 1'b1;
            tick();
        end
        valid_b = 1'b0;
        check("ovf_small_acc", 32'(acc_b), 5);

        // Test 5: restart mid-frame with a product on offer.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mul_a = tbl[i].a; mul_b = tbl[i].b; valid_a = 1'b1;
            tick();
        end
        check("restart_pre_acc", 32'(acc_a), 345);
        start_a = 1'b1; valid_a = 1'b1; mul_a = 4'd15; mul_b = 4'd15;
        tick();
        start_a = 1'b0; valid_a = 1'b0;
        check("restart_acc",   32'(acc_a),   0);
        check("restart_count", 32'(count_a), 0);
        check("restart_ovf",   32'(ovf_a),   0);
        check("restart_busy",  32'(busy_a),  1);
        tick();
        check("restart_hold_acc", 32'(acc_a), 0);
        run_table(1'b0, 1'b0, "after_restart");

        // Test 6a: reset during ACCUM.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mul_a = tbl[i].a; mul_b = tbl[i].b; valid_a = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; valid_a = 1'b0;
        check_all_zero("midreset");
        tick();
        check("midreset_idle_busy", 32'(busy_a), 0);

        // Test 6b: start from DONE clears and accumulates fresh.
        run_table(1'b1, 1'b0, "pre_done");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("donestart_acc",   32'(acc_a),   0);
        check("donestart_count", 32'(count_a), 0);
        check("donestart_busy",  32'(busy_a),  1);
        check("donestart_done",  32'(done_a),  0);
        run_table(1'b0, 1'b0, "fresh");

        // Random frames on both instances.
        for (int f = 0; f < 8; f++) rand_frame(0, f);
        for (int f = 0; f < 8; f++) rand_frame(1, f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
